spi_slave_stream: RTL and testbench

Parametrised SPI slave that carries a continuous stream of WIDTH-bit words per chip-select assertion, with a transmit FIFO and a receive FIFO on valid/ready interfaces. It is the successor to the single-frame busy-slave. It adds configurable word width, bit order, buffer depth, multi-word bursts, output-enable control and overrun/underrun reporting. It sits between the SPI pins and a fabric-side producer/consumer running on the oversampling clock.

---
 rtl/spi_slave_stream.sv | 268 ++++++++++++++++++++++++++
 tb/tb_spi_slave_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_stream.sv
// SPI slave carrying a continuous stream of WIDTH-bit words per select assertion,
// with valid/ready tx and rx FIFOs on the oversampling clock domain.
module spi_slave_stream #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        cpol_i,
    input  logic                        cpha_i,
    input  logic                        lsb_first_i,
    input  logic                        select_i,
    input  logic                        mclk_i,
    input  logic                        mosi_i,
    output logic                        miso_o,
    output logic                        miso_oe_o,
    input  logic [WIDTH-1:0]            tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic [WIDTH-1:0]            rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [$clog2(TX_DEPTH):0]   tx_level_o,
    output logic [$clog2(RX_DEPTH):0]   rx_level_o,
    output logic                        busy_o,
    output logic                        start_o,
    output logic                        done_o,
    output logic                        underrun_o,
    output logic                        overrun_o
);

    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned TCW = TAW + 1;
    localparam int unsigned RCW = RAW + 1;
    localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    function automatic logic head_bit(input logic [WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b,
                                                  input logic lsb);
        return lsb ? {b, w[WIDTH-1:1]} : {w[WIDTH-2:0], b};
    endfunction

    logic [1:0]       sel_sync_q, mclk_sync_q, mosi_sync_q;
    logic             sel_prev_q, mclk_prev_q;
    logic [0:0]       state_q, state_d;
    logic             busy_q, busy_d, oe_q, oe_d, start_q, start_d, done_q, done_d;
    logic             under_q, under_d, over_q, over_d, miso_q, miso_d, first_q, first_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_word_q, rx_word_d;
    logic             rx_push_q, rx_push_d;

    logic [WIDTH-1:0] tx_mem_q [TX_DEPTH];
    logic [WIDTH-1:0] tx_mem_d [TX_DEPTH];
    logic [TAW-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TCW-1:0]   tx_cnt_q, tx_cnt_d;
    logic             tx_ready_q, tx_ready_d;

    logic [WIDTH-1:0] rx_mem_q [RX_DEPTH];
    logic [WIDTH-1:0] rx_mem_d [RX_DEPTH];
    logic [RAW-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RCW-1:0]   rx_cnt_q, rx_cnt_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;

    logic             sel_s, mclk_s, mosi_s, rise_c, fall_c, sample_c, setup_c;
    logic             tx_load_c, tx_empty_c, rx_full_c, tx_push_c, tx_pop_c, rx_pop_c;
    logic [WIDTH-1:0] load_word_c, rx_next_c;

    // Edge decode on the synchronised mclk; mosi shares its delay.
    always_comb begin
        sel_s       = sel_sync_q[1];
        mclk_s      = mclk_sync_q[1];
        mosi_s      = mosi_sync_q[1];
        rise_c      = mclk_s & ~mclk_prev_q;
        fall_c      = ~mclk_s & mclk_prev_q;
        sample_c    = (cpha_i ^ cpol_i) ? fall_c : rise_c;
        setup_c     = (cpha_i ^ cpol_i) ? rise_c : fall_c;
        tx_empty_c  = (tx_cnt_q == '0);
        rx_full_c   = (rx_cnt_q == RCW'(RX_DEPTH));
        load_word_c = tx_empty_c ? '0 : tx_mem_q[tx_rd_q];
    end

    // Frame state machine: start/stop, bit counting, shifting and word handoff.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        oe_d      = oe_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        under_d   = 1'b0;
        over_d    = 1'b0;
        miso_d    = miso_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_word_d = rx_word_q;
        rx_push_d = 1'b0;
        tx_load_c = 1'b0;
        rx_next_c = shift_in(rx_sh_q, mosi_s, lsb_first_i);
        case (state_q)
            S_IDLE: begin
                if (sel_s && !sel_prev_q) begin
                    state_d   = S_ACTIVE;
                    start_d   = 1'b1;
                    busy_d    = 1'b1;
                    oe_d      = 1'b1;
                    cnt_d     = '0;
                    tx_load_c = 1'b1;
                    tx_sh_d   = load_word_c;
                    under_d   = tx_empty_c;
                    first_d   = cpha_i;
                    if (!cpha_i) miso_d = head_bit(load_word_c, lsb_first_i);
                end
            end
            default: begin
                if (sample_c) begin
                    rx_sh_d = rx_next_c;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d     = '0;
                        done_d    = 1'b1;
                        tx_load_c = 1'b1;
                        tx_sh_d   = load_word_c;
                        under_d   = tx_empty_c;
                        first_d   = 1'b1;
                        if (rx_full_c) begin
                            over_d = 1'b1;
                        end else begin
                            rx_push_d = 1'b1;
                            rx_word_d = rx_next_c;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (setup_c) begin
                    // A freshly loaded word presents its first bit without shifting.
                    if (first_q) begin
                        miso_d  = head_bit(tx_sh_q, lsb_first_i);
                        first_d = 1'b0;
                    end else begin
                        tx_sh_d = shift_out(tx_sh_q, lsb_first_i);
                        miso_d  = head_bit(tx_sh_d, lsb_first_i);
                    end
                end
                if (!sel_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                end
            end
        endcase
    end

    // Transmit and receive FIFOs.
    always_comb begin
        tx_push_c = tx_valid_i & tx_ready_q;
        tx_pop_c  = tx_load_c & ~tx_empty_c;
        tx_mem_d  = tx_mem_q;
        if (tx_push_c) tx_mem_d[tx_wr_q] = tx_data_i;
        tx_wr_d    = tx_wr_q + TAW'(tx_push_c);
        tx_rd_d    = tx_rd_q + TAW'(tx_pop_c);
        tx_cnt_d   = tx_cnt_q + TCW'(tx_push_c) - TCW'(tx_pop_c);
        tx_ready_d = (tx_cnt_d != TCW'(TX_DEPTH));

        rx_pop_c = rx_valid_q & rx_ready_i;
        rx_mem_d = rx_mem_q;
        if (rx_push_q) rx_mem_d[rx_wr_q] = rx_word_q;
        rx_wr_d    = rx_wr_q + RAW'(rx_push_q);
        rx_rd_d    = rx_rd_q + RAW'(rx_pop_c);
        rx_cnt_d   = rx_cnt_q + RCW'(rx_push_q) - RCW'(rx_pop_c);
        rx_valid_d = (rx_cnt_d != '0);
        rx_data_d  = rx_data_q;
        if (rx_push_q && (rx_cnt_q == RCW'(rx_pop_c))) rx_data_d = rx_word_q;
        else if (rx_cnt_d != '0)                       rx_data_d = rx_mem_q[rx_rd_d];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sel_sync_q  <= 2'b11;
            sel_prev_q  <= 1'b1;
            mclk_sync_q <= '0;
            mosi_sync_q <= '0;
            mclk_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            oe_q        <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            under_q     <= 1'b0;
            over_q      <= 1'b0;
            miso_q      <= 1'b0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_word_q   <= '0;
            rx_push_q   <= 1'b0;
            for (int unsigned i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
            for (int unsigned i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            tx_ready_q  <= 1'b1;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            sel_sync_q  <= {sel_sync_q[0], select_i};
            sel_prev_q  <= sel_s;
            mclk_sync_q <= {mclk_sync_q[0], mclk_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            mclk_prev_q <= mclk_s;
            state_q     <= state_d;
            busy_q      <= busy_d;
            oe_q        <= oe_d;
            start_q     <= start_d;
            done_q      <= done_d;
            under_q     <= under_d;
            over_q      <= over_d;
            miso_q      <= miso_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_word_q   <= rx_word_d;
            rx_push_q   <= rx_push_d;
            tx_mem_q    <= tx_mem_d;
            rx_mem_q    <= rx_mem_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_ready_q  <= tx_ready_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign miso_o     = miso_q;
    assign miso_oe_o  = oe_q;
    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_level_o = tx_cnt_q;
    assign rx_level_o = rx_cnt_q;
    assign busy_o     = busy_q;
    assign start_o    = start_q;
    assign done_o     = done_q;
    assign underrun_o = under_q;
    assign overrun_o  = over_q;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: a bit-level SPI master model drives frames
// and the collected miso/rx words are compared against hand-computed values.
module tb_spi_slave_stream;

    localparam int unsigned W   = 8;
    localparam int unsigned TXD = 4;
    localparam int unsigned RXD = 4;

    logic         clk = 1'b0;
    logic         reset, cpol, cpha, lsb_first, select, mclk, mosi;
    logic         miso, miso_oe, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [W-1:0] tx_data, rx_data;
    logic [2:0]   tx_level, rx_level;
    logic         busy, start, done, underrun, overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int start_cnt = 0, done_cnt = 0, und_cnt = 0, ovr_cnt = 0;
    int und_snap = 0;
    int b_start, b_done, b_und, b_ovr;

    logic [7:0] m_tx [8];
    logic [7:0] m_rx [8];

    spi_slave_stream #(.WIDTH(W), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk_i(clk), .reset_i(reset), .cpol_i(cpol), .cpha_i(cpha),
        .lsb_first_i(lsb_first), .select_i(select), .mclk_i(mclk), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_level_o(tx_level), .rx_level_o(rx_level),
        .busy_o(busy), .start_o(start), .done_o(done),
        .underrun_o(underrun), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (start)    start_cnt++;
        if (done)     done_cnt++;
        if (underrun) und_cnt++;
        if (overrun)  ovr_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    task automatic snap();
        b_start = start_cnt; b_done = done_cnt; b_und = und_cnt; b_ovr = ovr_cnt;
    endtask

    task automatic tx_push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic rx_pop(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        check(tag, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    // Master model: half mclk period = 4 clk cycles; frame of nbits then deselect.
    task automatic spi_frame(input int nbits);
        int w, bp;
        mclk = cpol;
        repeat (4) @(negedge clk);
        select = 1'b1;
        repeat (6) @(negedge clk);
        und_snap = und_cnt;
        for (int b = 0; b < nbits; b++) begin
            w  = b / 8;
            bp = lsb_first ? (b % 8) : (7 - (b % 8));
            if (!cpha) begin
                mosi = m_tx[w][bp];
                repeat (4) @(negedge clk);
                m_rx[w][bp] = miso;
                mclk = ~cpol;
                repeat (4) @(negedge clk);
                mclk = cpol;
            end else begin
                mclk = ~cpol;
                mosi = m_tx[w][bp];
                repeat (4) @(negedge clk);
                m_rx[w][bp] = miso;
                mclk = cpol;
                repeat (4) @(negedge clk);
            end
        end
        repeat (8) @(negedge clk);
        select = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_drop", 32'(busy), 32'd0);
        check("oe_drop", 32'(miso_oe), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        select = 1'b0; mclk = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_tx_level", 32'(tx_level), 32'd0);
        check("rst_rx_level", 32'(rx_level), 32'd0);
        check("rst_pulses", 32'({start, done, underrun, overrun}), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("no_start_after_rst", 32'(start_cnt), 32'd0);

        // Two-word burst, mode 0, MSB first; a third word covers the final load.
        tx_push(8'hA5); tx_push(8'h3C); tx_push(8'h5A);
        check("t1_tx_level", 32'(tx_level), 32'd3);
        m_tx[0] = 8'h12; m_tx[1] = 8'h34;
        snap();
        spi_frame(16);
        check("t1_miso0", 32'(m_rx[0]), 32'hA5);
        check("t1_miso1", 32'(m_rx[1]), 32'h3C);
        check("t1_done", 32'(done_cnt - b_done), 32'd2);
        check("t1_start", 32'(start_cnt - b_start), 32'd1);
        check("t1_underrun", 32'(und_cnt - b_und), 32'd0);
        check("t1_rx_level", 32'(rx_level), 32'd2);
        check("t1_tx_level_end", 32'(tx_level), 32'd0);
        rx_pop("t1_rx0", 8'h12);
        rx_pop("t1_rx1", 8'h34);
        check("t1_rx_empty", 32'(rx_valid), 32'd0);

        // All four modes, LSB first, 0x81 both ways.
        lsb_first = 1'b1;
        for (int m = 0; m < 4; m++) begin
            cpol = (m >= 2);
            cpha = (m % 2) == 1;
            tx_push(8'h81);
            m_tx[0] = 8'h81;
            m_rx[0] = 8'h00;
            spi_frame(8);
            check($sformatf("t2_miso_m%0d", m), 32'(m_rx[0]), 32'h81);
            rx_pop($sformatf("t2_rx_m%0d", m), 8'h81);
        end

        // Empty tx FIFO at frame start.
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        check("t3_tx_empty", 32'(tx_level), 32'd0);
        m_tx[0] = 8'h5C;
        snap();
        spi_frame(8);
        check("t3_underrun_start", 32'(und_snap - b_und), 32'd1);
        check("t3_miso", 32'(m_rx[0]), 32'h00);
        rx_pop("t3_rx", 8'h5C);

        // rx overrun with consumer stalled.
        m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33; m_tx[3] = 8'h44; m_tx[4] = 8'h55;
        snap();
        spi_frame(40);
        check("t4_rx_level", 32'(rx_level), 32'(RXD));
        check("t4_overrun", 32'(ovr_cnt - b_ovr), 32'd1);
        check("t4_done", 32'(done_cnt - b_done), 32'd5);
        rx_pop("t4_rx0", 8'h11);
        rx_pop("t4_rx1", 8'h22);
        rx_pop("t4_rx2", 8'h33);
        rx_pop("t4_rx3", 8'h44);
        check("t4_rx_empty", 32'(rx_valid), 32'd0);

        // Partial word then a clean word.
        m_tx[0] = 8'hF0;
        snap();
        spi_frame(5);
        check("t5_no_done", 32'(done_cnt - b_done), 32'd0);
        check("t5_rx_level", 32'(rx_level), 32'd0);
        m_tx[0] = 8'h96;
        snap();
        spi_frame(8);
        check("t5_done", 32'(done_cnt - b_done), 32'd1);
        rx_pop("t5_rx", 8'h96);

        // Reset mid-word with select held high.
        tx_push(8'hAA); tx_push(8'h55);
        mclk = 1'b0;
        select = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_miso_pre", 32'(miso), 32'd1);
        for (int k = 0; k < 3; k++) begin
            mclk = 1'b1; repeat (4) @(negedge clk);
            mclk = 1'b0; repeat (4) @(negedge clk);
        end
        snap();
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_oe", 32'(miso_oe), 32'd0);
        check("t6_miso", 32'(miso), 32'd0);
        check("t6_tx_level", 32'(tx_level), 32'd0);
        check("t6_tx_ready", 32'(tx_ready), 32'd1);
        check("t6_rx_level", 32'(rx_level), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_start", 32'(start_cnt - b_start), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        select = 1'b0;
        repeat (4) @(negedge clk);
        select = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_restart", 32'(start_cnt - b_start), 32'd1);
        check("t6_busy_again", 32'(busy), 32'd1);
        check("t6_no_done", 32'(done_cnt - b_done), 32'd0);
        select = 1'b0;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
